tfg_stage_buffer: RTL and testbench



---
 rtl/tfg_pkg.sv | 20 ++
 rtl/tfg_stage_buffer_if.sv | 30 +++
 rtl/tfg_buf_bank.sv | 19 +
 rtl/tfg_stage_buffer.sv | 123 ++++++++++++
 tb/tb_tfg_stage_buffer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/tfg_pkg.sv
// tfg_pkg: shared defaults, read FSM states and frame-length helper for tfg_stage_buffer
package tfg_pkg;
  localparam int MAX_BW_DEF = 62;
  localparam int N_DEF = 16;
  localparam int DEPTH_DEF = 2048;
  typedef enum logic [1:0] {IDLE, FETCH, STREAM} rd_state_e;
  typedef struct packed {
    logic [31:0] len;
    logic        clamp;
  } frame_cfg_t;
  function automatic frame_cfg_t frame_len(input logic [3:0] log2n, input int n, input int depth);
    frame_cfg_t r;
    logic [31:0] l;
    l = (32'd1 << log2n) / $unsigned(n);
    l = (l == 32'd0) ? 32'd1 : l;
    r.clamp = l > $unsigned(depth);
    r.len = r.clamp ? $unsigned(depth) : l;
    return r;
  endfunction
endpackage

// File: rtl/tfg_stage_buffer_if.sv
// tfg_stage_buffer_if: generator beat input, butterfly valid/ready output and status flags; optional i_replay with TFG_BUF_REPLAY_EN
interface tfg_stage_buffer_if #(parameter int MAX_BW = 62, parameter int N = 16);
  logic                  i_valid;
  logic [N*MAX_BW-1:0]   i_tfg;
  logic [3:0]            i_log2N;
`ifdef TFG_BUF_REPLAY_EN
  logic [3:0]            i_replay;
`endif
  logic                  o_valid;
  logic                  i_ready;
  logic [N*MAX_BW-1:0]   o_tfg;
  logic                  o_last;
  logic [1:0]            o_bank_full;
  logic                  o_ovf;
  logic                  o_cfg_err;
  modport master (
`ifdef TFG_BUF_REPLAY_EN
    output i_replay,
`endif
    output i_valid, i_tfg, i_log2N, i_ready,
    input  o_valid, o_tfg, o_last, o_bank_full, o_ovf, o_cfg_err
  );
  modport slave (
`ifdef TFG_BUF_REPLAY_EN
    input  i_replay,
`endif
    input  i_valid, i_tfg, i_log2N, i_ready,
    output o_valid, o_tfg, o_last, o_bank_full, o_ovf, o_cfg_err
  );
endinterface

// File: rtl/tfg_buf_bank.sv
// tfg_buf_bank: simple dual-port RAM (clk, we/waddr/wdata write port, re/raddr/rdata 1-cycle synchronous read port)
module tfg_buf_bank #(
  parameter int W  = 992,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/tfg_stage_buffer.sv
// tfg_stage_buffer: ping-pong twiddle buffer; ports clk, rst_n (async low), bus (slave: generator beats in, valid/ready beats out, status); TFG_BUF_REPLAY_EN adds per-frame replay
module tfg_stage_buffer
  import tfg_pkg::*;
#(
  parameter int MAX_BW = MAX_BW_DEF,
  parameter int N      = N_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input logic clk,
  input logic rst_n,
  tfg_stage_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = N * MAX_BW;
  rd_state_e state_q, state_d;
  logic [1:0] full_q, full_d, done_q, done_d;
  logic [1:0][AW-1:0] last_q;
  logic [AW-1:0] wptr_q, wptr_d, wlast, wlast_new, iptr_q;
  logic [3:0] ipass_q, rep;
  logic wbank_q, ibank_q, rbank_q, ovf_q, cfg_err_q;
  logic wr, wfin, re, ilast, ifin, slot, adv, hs, clr, nxt_ok;
  logic s1_v_q, s1_last_q, s1_fend_q, out_v_q, out_last_q, out_fend_q;
  logic [W-1:0] out_q, rdata;
  frame_cfg_t fl;
  assign fl = frame_len(bus.i_log2N, N, DEPTH);
  assign wlast_new = AW'(fl.len - 32'd1);
  // The first beat of a frame carries its own length, so a 1-beat frame completes immediately
  assign wlast = (wptr_q == '0) ? wlast_new : last_q[wbank_q];
  assign wr = bus.i_valid && !full_q[wbank_q];
  assign wfin = wr && (wptr_q == wlast);
  assign wptr_d = wr ? (wfin ? '0 : wptr_q + AW'(1)) : wptr_q;
  // Two-stage read pipe: RAM output (s1) then output register; s1 only refills when it drains
  assign adv = !out_v_q || bus.i_ready;
  assign hs = out_v_q && bus.i_ready;
  assign slot = !s1_v_q || adv;
  // done marks a bank whose reads are all issued but whose final beat is still in the pipe
  assign re = (state_q != IDLE) && full_q[ibank_q] && !done_q[ibank_q] && slot;
  assign ilast = iptr_q == last_q[ibank_q];
  assign ifin = ilast && (ipass_q == rep);
  assign clr = hs && out_fend_q;
`ifdef TFG_BUF_REPLAY_EN
  logic [1:0][3:0] rep_q;
  assign rep = rep_q[ibank_q];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rep_q <= '0;
    else if (wr && wptr_q == '0) rep_q[wbank_q] <= bus.i_replay;
`else
  assign rep = '0;
`endif
  always_comb begin
    full_d = full_q;
    if (wfin) full_d[wbank_q] = 1'b1;
    if (clr) full_d[rbank_q] = 1'b0;
    done_d = done_q;
    if (re && ifin) done_d[ibank_q] = 1'b1;
    if (clr) done_d[rbank_q] = 1'b0;
    nxt_ok = full_d[!ibank_q] && !done_d[!ibank_q];
    state_d = (state_q == IDLE) ? ((full_d[ibank_q] && !done_d[ibank_q]) ? FETCH : IDLE) :
              !re ? state_q : (ifin ? (nxt_ok ? STREAM : IDLE) : STREAM);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      full_q <= '0;
      done_q <= '0;
      last_q <= '0;
      wptr_q <= '0;
      wbank_q <= 1'b0;
      ibank_q <= 1'b0;
      rbank_q <= 1'b0;
      iptr_q <= '0;
      ipass_q <= '0;
      ovf_q <= 1'b0;
      cfg_err_q <= 1'b0;
      s1_v_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_fend_q <= 1'b0;
      out_v_q <= 1'b0;
      out_last_q <= 1'b0;
      out_fend_q <= 1'b0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      full_q <= full_d;
      done_q <= done_d;
      wptr_q <= wptr_d;
      wbank_q <= wbank_q ^ wfin;
      ibank_q <= ibank_q ^ (re && ifin);
      rbank_q <= rbank_q ^ clr;
      if (wr && wptr_q == '0) last_q[wbank_q] <= wlast_new;
      ovf_q <= ovf_q | (bus.i_valid && full_q[wbank_q]);
      cfg_err_q <= cfg_err_q | (wr && wptr_q == '0 && fl.clamp);
      if (re) begin
        iptr_q <= ilast ? '0 : iptr_q + AW'(1);
        ipass_q <= !ilast ? ipass_q : (ifin ? '0 : ipass_q + 4'd1);
        s1_last_q <= ilast;
        s1_fend_q <= ifin;
      end
      s1_v_q <= re || (s1_v_q && !adv);
      if (adv) begin
        out_v_q <= s1_v_q;
        out_last_q <= s1_v_q && s1_last_q;
        out_fend_q <= s1_v_q && s1_fend_q;
        if (s1_v_q) out_q <= rdata;
      end
    end
  end
  tfg_buf_bank #(.W(W), .AW(AW + 1)) u_bank (
    .clk   (clk),
    .we    (wr),
    .waddr ({wbank_q, wptr_q}),
    .wdata (bus.i_tfg),
    .re    (re),
    .raddr ({ibank_q, iptr_q}),
    .rdata (rdata)
  );
  assign bus.o_valid = out_v_q;
  assign bus.o_tfg = out_q;
  assign bus.o_last = out_last_q;
  assign bus.o_bank_full = full_q;
  assign bus.o_ovf = ovf_q;
  assign bus.o_cfg_err = cfg_err_q;
endmodule

// File: tb/tb_tfg_stage_buffer.sv
// tb_tfg_stage_buffer: scoreboard and table-driven bench for tfg_stage_buffer
module tb_tfg_stage_buffer;
  localparam int MAX_BW = 62;
  localparam int N = 16;
  localparam int DEPTH = 8;
  localparam int W = N * MAX_BW;
  typedef struct {
    logic [W-1:0] d;
    logic         last;
  } exp_t;
  typedef struct {
    logic [3:0] log2n;
    int         len;
    int         rmode;
    logic       cfg_err;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  int cur_rep = 0;
  exp_t q[$];
  logic prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  vec_t vecs[7];
  tfg_stage_buffer_if #(.MAX_BW(MAX_BW), .N(N)) ifc();
  tfg_stage_buffer #(.MAX_BW(MAX_BW), .N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] mk(int f, int b);
    logic [W-1:0] r;
    for (int j = 0; j < N; j++) r[j*MAX_BW +: MAX_BW] = {f[19:0], b[19:0], 22'(j)};
    return r;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input int f, input logic [3:0] l2, input int len, input bit push);
    for (int b = 0; b < len; b++) begin
      ifc.i_valid = 1'b1;
      ifc.i_tfg = mk(f, b);
      ifc.i_log2N = l2;
`ifdef TFG_BUF_REPLAY_EN
      ifc.i_replay = 4'(cur_rep);
`endif
      tick;
    end
    ifc.i_valid = 1'b0;
    if (push)
      for (int p = 0; p <= cur_rep; p++)
        for (int b = 0; b < len; b++) q.push_back('{mk(f, b), b == len - 1});
  endtask
  task automatic drain(input int mode);
    int c;
    for (c = 0; c < 600 && (q.size() != 0 || ifc.o_valid); c++) begin
      ifc.i_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~ifc.i_ready : 1'($urandom_range(0, 1));
      tick;
    end
    ifc.i_ready = 1'b1;
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask
  task automatic wait_hs(input int n);
    int c;
    for (c = 0; c < 200 && hs_count < n; c++) tick;
    chk("hs_wait", 64'(hs_count >= n), 64'd1);
  endtask
  always @(negedge clk) begin
    if (!rst_n) prev_stall <= 1'b0;
    else begin
      if (prev_stall) begin
        checks++;
        if (!ifc.o_valid || ifc.o_tfg !== prev_data) begin
          failures++;
          $display("FAIL hold: valid=%0b tfg=%0h expected held %0h", ifc.o_valid, ifc.o_tfg[63:0], prev_data[63:0]);
        end
      end
      prev_stall <= ifc.o_valid && !ifc.i_ready;
      prev_data <= ifc.o_tfg;
      if (ifc.o_valid && ifc.i_ready) begin
        hs_count++;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL extra_beat: got %0h expected no beat", ifc.o_tfg[63:0]);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (ifc.o_tfg !== e.d || ifc.o_last !== e.last) begin
            failures++;
            $display("FAIL beat: got %0h last=%0b expected %0h last=%0b", ifc.o_tfg[63:0], ifc.o_last, e.d[63:0], e.last);
          end
        end
      end
    end
  end
  initial begin
    int run;
    vecs[0] = '{4'd5, 2, 0, 1'b0};
    vecs[1] = '{4'd7, 8, 1, 1'b0};
    vecs[2] = '{4'd4, 1, 2, 1'b0};
    vecs[3] = '{4'd0, 1, 1, 1'b0};
    vecs[4] = '{4'd6, 4, 2, 1'b0};
    vecs[5] = '{4'd7, 8, 2, 1'b0};
    vecs[6] = '{4'd8, 8, 1, 1'b1};
    ifc.i_valid = 1'b0;
    ifc.i_tfg = '0;
    ifc.i_log2N = '0;
    ifc.i_ready = 1'b0;
`ifdef TFG_BUF_REPLAY_EN
    ifc.i_replay = '0;
`endif
    rst_n = 1'b0;
    tick;
    tick;
    chk("rst_valid", 64'(ifc.o_valid), 64'd0);
    chk("rst_tfg", 64'(|ifc.o_tfg), 64'd0);
    chk("rst_last", 64'(ifc.o_last), 64'd0);
    chk("rst_full", 64'(ifc.o_bank_full), 64'd0);
    chk("rst_ovf", 64'(ifc.o_ovf), 64'd0);
    chk("rst_cfg", 64'(ifc.o_cfg_err), 64'd0);
    rst_n = 1'b1;
    tick;
    ifc.i_ready = 1'b1;
    send(1, 4'd5, 2, 1);
    chk("lat_t1", 64'(ifc.o_valid), 64'd0);
    tick;
    chk("lat_t2", 64'(ifc.o_valid), 64'd0);
    tick;
    chk("lat_t3", 64'(ifc.o_valid), 64'd1);
    drain(0);
    ifc.i_ready = 1'b0;
    send(2, 4'd5, 2, 1);
    send(3, 4'd5, 2, 1);
    send(4, 4'd5, 2, 0);
    repeat (4) tick;
    chk("ovf_full", 64'(ifc.o_bank_full), 64'd3);
    chk("ovf_flag", 64'(ifc.o_ovf), 64'd1);
    drain(0);
    chk("ovf_empty", 64'(ifc.o_bank_full), 64'd0);
    ifc.i_ready = 1'b0;
    send(5, 4'd5, 2, 1);
    send(6, 4'd5, 2, 1);
    repeat (4) tick;
    ifc.i_ready = 1'b1;
    run = 0;
    for (int c = 0; c < 10; c++) begin
      if (ifc.o_valid) run++;
      else if (run > 0) break;
      tick;
    end
    chk("no_gap", 64'(run), 64'd4);
    drain(0);
    for (int i = 0; i < 7; i++) begin
      ifc.i_ready = 1'b0;
      send(10 + 2 * i, vecs[i].log2n, vecs[i].len, 1);
      send(11 + 2 * i, vecs[i].log2n, vecs[i].len, 1);
      drain(vecs[i].rmode);
      chk("vec_full", 64'(ifc.o_bank_full), 64'd0);
      chk("vec_cfg", 64'(ifc.o_cfg_err), 64'(vecs[i].cfg_err));
    end
    ifc.i_ready = 1'b1;
    hs_count = 0;
    send(40, 4'd7, 8, 1);
    wait_hs(3);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("mid_valid", 64'(ifc.o_valid), 64'd0);
    chk("mid_tfg", 64'(|ifc.o_tfg), 64'd0);
    chk("mid_last", 64'(ifc.o_last), 64'd0);
    chk("mid_full", 64'(ifc.o_bank_full), 64'd0);
    chk("mid_ovf", 64'(ifc.o_ovf), 64'd0);
    chk("mid_cfg", 64'(ifc.o_cfg_err), 64'd0);
    tick;
    rst_n = 1'b1;
    tick;
    send(41, 4'd5, 2, 1);
    drain(0);
`ifdef TFG_BUF_REPLAY_EN
    cur_rep = 2;
    hs_count = 0;
    send(50, 4'd5, 2, 1);
    wait_hs(5);
    chk("rep_held", 64'(|ifc.o_bank_full), 64'd1);
    drain(0);
    chk("rep_free", 64'(ifc.o_bank_full), 64'd0);
    cur_rep = 0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
